pb_event_scheduler: RTL

PB_EVENT_SCHEDULER -- requirements
Module: pb_event_scheduler

---
 rtl/pb_event_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pb_event_scheduler.sv
// pb_event_scheduler: N push buttons, each turned into a single-cycle press
// by its own edge FSM. Presses latch into per-button pending flags, and a
// round-robin arbiter drains them into a valid/ready event slot.
// Optional feature macro: PB_DEBOUNCE_EN inserts a per-bit debounce filter
// ahead of each edge FSM. The default build (macro undefined) has no filter.
module pb_event_scheduler #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   pb,
  input  logic           ev_ready,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic [N-1:0]   pend,
  output logic           drop
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } edge_state_e;

  logic [N-1:0]   lvl_s;
  logic [N-1:0]   press_s;
  logic [N-1:0]   grant_mask_s;
  logic [IDW-1:0] grant_idx_s;
  logic           found_s;
  logic           slot_free_s;

  edge_state_e    state_q [N];
  edge_state_e    state_d [N];
  logic [N-1:0]   pend_q, pend_d;
  logic           ev_valid_q, ev_valid_d;
  logic [IDW-1:0] ev_id_q, ev_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           drop_q, drop_d;

`ifdef PB_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] db_cnt_q [N];
  logic [CW-1:0] db_cnt_d [N];
  logic [N-1:0]  db_filt_q, db_filt_d;

  // Debounce next state: count while raw differs from filtered, adopt raw after DB_CYCLES.
  always_comb begin
    db_filt_d = db_filt_q;
    for (int i = 0; i < N; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (pb[i] != db_filt_q[i]) begin
        if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          db_filt_d[i] = pb[i];
          db_cnt_d[i]  = {CW{1'b0}};
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end else begin
        db_cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_filt_q <= {N{1'b0}};
      for (int i = 0; i < N; i++) db_cnt_q[i] <= {CW{1'b0}};
    end else begin
      db_filt_q <= db_filt_d;
      for (int i = 0; i < N; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign lvl_s = db_filt_q;
`else
  logic unused_db_s;
  assign unused_db_s = (DB_CYCLES > 0);
  assign lvl_s       = pb;
`endif

  // Edge FSM next state per button; PRESS lasts exactly one cycle per press.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      press_s[i] = 1'b0;
      case (state_q[i])
        ST_IDLE:  state_d[i] = lvl_s[i] ? ST_PRESS : ST_IDLE;
        ST_PRESS: begin
          press_s[i] = 1'b1;
          state_d[i] = ST_HELD;
        end
        ST_HELD:  state_d[i] = lvl_s[i] ? ST_HELD : ST_IDLE;
        default:  state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Round-robin search: first pending index after ptr, wrapping through ptr itself.
  always_comb begin
    logic [IDW-1:0] idx_v;
    grant_idx_s = {IDW{1'b0}};
    found_s     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx_v       = IDW'((int'(ptr_q) + k) % N);
      grant_idx_s = (!found_s && pend_q[idx_v]) ? idx_v : grant_idx_s;
      found_s     = found_s | pend_q[idx_v];
    end
  end

  // Slot/grant/pending next state; a handshake and the next grant share one edge.
  always_comb begin
    slot_free_s  = !ev_valid_q || ev_ready;
    grant_mask_s = {N{1'b0}};
    ev_valid_d   = ev_valid_q;
    ev_id_d      = ev_id_q;
    ptr_d        = ptr_q;
    if (slot_free_s && found_s) begin
      grant_mask_s[grant_idx_s] = 1'b1;
      ev_valid_d                = 1'b1;
      ev_id_d                   = grant_idx_s;
      ptr_d                     = grant_idx_s;
    end else if (slot_free_s) begin
      ev_valid_d = 1'b0;
    end else begin
      ev_valid_d = ev_valid_q;
    end
    // A press on a flag being granted this cycle re-arms it without loss.
    pend_d = (pend_q & ~grant_mask_s) | press_s;
    drop_d = |(press_s & pend_q & ~grant_mask_s);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) state_q[i] <= ST_IDLE;
      pend_q     <= {N{1'b0}};
      ev_valid_q <= 1'b0;
      ev_id_q    <= {IDW{1'b0}};
      ptr_q      <= IDW'(N - 1);
      drop_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
      pend_q     <= pend_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      ptr_q      <= ptr_d;
      drop_q     <= drop_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign pend     = pend_q;
  assign drop     = drop_q;

endmodule
